// File: rtl/lsu_pkg.sv
// Shared LSU definitions: func3 encodings, store FSM states and access-size decode.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } st_state_t;

  // Store size in bytes; 0 marks an encoding that is not a legal store.
  function automatic logic [2:0] st_size(input logic [2:0] func3);
    case (func3)
      F3_SB:   st_size = 3'd1;
      F3_SH:   st_size = 3'd2;
      F3_SW:   st_size = 3'd4;
      default: st_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/st_lane_shift.sv
// Combinational lane steering for one store beat: shifted data, byte strobes and legality.
module st_lane_shift
  import lsu_pkg::*;
(
  input  logic [2:0]        func3,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] data,
  input  logic              beat_sel,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              need_split,
  output logic              illegal
);

  logic [2:0]          size;
  logic [7:0]          mask;
  logic [2*DATA_W-1:0] shifted;
  logic [DATA_W-1:0]   lane_data;

  // Build an 8-byte window spanning both beats, then pick the half for this beat.
  always_comb begin
    size       = st_size(func3);
    illegal    = (size == 3'd0);
    need_split = !illegal && ((4'(offset) + 4'(size)) > 4'd4);
    mask       = 8'((8'd1 << size) - 8'd1);
    mask       = mask << offset;
    shifted    = (2*DATA_W)'(data) << {offset, 3'b000};
    wstrb      = beat_sel ? mask[7:4] : mask[3:0];
    lane_data  = beat_sel ? shifted[2*DATA_W-1:DATA_W] : shifted[DATA_W-1:0];
    wdata      = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      wdata[8*i +: 8] = lane_data[8*i +: 8] & {8{wstrb[i]}};
    end
  end

endmodule

// File: rtl/st_align_unit.sv
// Store alignment unit: turns sb/sh/sw requests into word-aligned write beats,
// splitting word-crossing stores into two beats behind a single holding register.
module st_align_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SPLIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              st_done,
  output logic              st_err
);

  st_state_t         state;
  logic [2:0]        func3_q;
  logic [1:0]        offset_q;
  logic [DATA_W-1:0] data_q;
  logic              split_q;

  logic [2:0]        ls_func3;
  logic [1:0]        ls_offset;
  logic [DATA_W-1:0] ls_data;
  logic              ls_beat_sel;
  logic [DATA_W-1:0] ls_wdata;
  logic [STRB_W-1:0] ls_wstrb;
  logic              ls_need_split;
  logic              ls_illegal;
  logic              accept;
  logic              reject;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // The shifter sees the live request while idle and the held request while busy.
  always_comb begin
    ls_beat_sel = (state != ST_IDLE);
    ls_func3    = ls_beat_sel ? func3_q  : req_func3;
    ls_offset   = ls_beat_sel ? offset_q : req_addr[1:0];
    ls_data     = ls_beat_sel ? data_q   : req_data;
    reject      = ls_illegal || (ls_need_split && (SPLIT_EN == 0));
  end

  st_lane_shift u_lane_shift (
    .func3      (ls_func3),
    .offset     (ls_offset),
    .data       (ls_data),
    .beat_sel   (ls_beat_sel),
    .wdata      (ls_wdata),
    .wstrb      (ls_wstrb),
    .need_split (ls_need_split),
    .illegal    (ls_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      func3_q   <= '0;
      offset_q  <= '0;
      data_q    <= '0;
      split_q   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            func3_q  <= req_func3;
            offset_q <= req_addr[1:0];
            data_q   <= req_data;
            split_q  <= ls_need_split;
            if (reject) begin
              st_done <= 1'b1;
              st_err  <= 1'b1;
            end else begin
              state     <= ST_BEAT0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= ls_wdata;
              mem_wstrb <= ls_wstrb;
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ready) begin
            if (split_q) begin
              state     <= ST_BEAT1;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_wdata <= ls_wdata;
              mem_wstrb <= ls_wstrb;
            end else begin
              state     <= ST_IDLE;
              mem_valid <= 1'b0;
              mem_wdata <= '0;
              mem_wstrb <= '0;
              st_done   <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ready) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            st_done   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_align_unit.sv
// Directed self-checking bench for st_align_unit (split-enabled and split-disabled builds).
module tb_st_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_data;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        st_done, st_err;

  logic        r1_valid, r1_ready;
  logic [2:0]  r1_func3;
  logic [31:0] r1_addr, r1_data;
  logic        m1_valid, m1_ready;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        d1_done, d1_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  st_align_unit #(.ADDR_W(32), .SPLIT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func3(req_func3),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .st_done(st_done), .st_err(st_err)
  );

  st_align_unit #(.ADDR_W(32), .SPLIT_EN(0)) dut_nosplit (
    .clk(clk), .rst(rst),
    .req_valid(r1_valid), .req_ready(r1_ready), .req_func3(r1_func3),
    .req_addr(r1_addr), .req_data(r1_data),
    .mem_valid(m1_valid), .mem_ready(m1_ready), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_wstrb(m1_wstrb),
    .st_done(d1_done), .st_err(d1_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of cycle T+1.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_func3 = f3;
    req_addr  = a;
    req_data  = d;
    chk("req_ready_at_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    chk({tag, "_valid"}, 64'(mem_valid), 64'd1);
    chk({tag, "_addr"},  64'(mem_addr),  64'(a));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(w));
    chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'(s));
    chk({tag, "_nodone"}, 64'(st_done), 64'd0);
  endtask

  task automatic done(input string tag, input logic err);
    chk({tag, "_done"},  64'(st_done),   64'd1);
    chk({tag, "_err"},   64'(st_err),    64'(err));
    chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_func3 = '0; req_addr = '0; req_data = '0; mem_ready = 1'b1;
    r1_valid = 1'b0; r1_func3 = '0; r1_addr = '0; r1_data = '0; m1_ready = 1'b1;

    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_done",  64'(st_done),   64'd0);
    chk("rst_addr",  64'(mem_addr),  64'd0);
    chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // sb at lane 3
    send(3'b000, 32'h0000_1003, 32'h0000_00AB);
    beat("sb_b0", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
    @(negedge clk);
    done("sb", 1'b0);

    // sh crossing a word boundary, issued back-to-back in the done cycle
    send(3'b001, 32'h0000_2003, 32'h0000_1234);
    beat("sh_b0", 32'h0000_2000, 32'h3400_0000, 4'b1000);
    @(negedge clk);
    beat("sh_b1", 32'h0000_2004, 32'h0000_0012, 4'b0001);
    @(negedge clk);
    done("sh", 1'b0);

    // sw split with beat 0 stalled for three cycles
    mem_ready = 1'b0;
    send(3'b010, 32'h0000_3001, 32'hDEAD_BEEF);
    beat("sw_b0", 32'h0000_3000, 32'hADBE_EF00, 4'b1110);
    repeat (3) begin
      @(negedge clk);
      beat("sw_b0_stall", 32'h0000_3000, 32'hADBE_EF00, 4'b1110);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    beat("sw_b1", 32'h0000_3004, 32'h0000_00DE, 4'b0001);
    @(negedge clk);
    done("sw", 1'b0);

    // illegal func3 values
    send(3'b011, 32'h0000_0000, 32'h1111_1111);
    done("f3_011", 1'b1);
    @(negedge clk);
    send(3'b110, 32'h0000_0010, 32'h1111_1111);
    done("f3_110", 1'b1);

    // unstrobed bytes are driven to zero
    send(3'b000, 32'h0000_5000, 32'hFFFF_FF5A);
    beat("sb_mask", 32'h0000_5000, 32'h0000_005A, 4'b0001);
    @(negedge clk);
    done("sb_mask", 1'b0);
    send(3'b001, 32'h0000_7002, 32'hAAAA_5678);
    beat("sh_hi", 32'h0000_7000, 32'h5678_0000, 4'b1100);
    @(negedge clk);
    done("sh_hi", 1'b0);

    // reset while beat 1 is stalled
    send(3'b001, 32'h0000_2003, 32'h0000_1234);
    @(negedge clk);
    mem_ready = 1'b0;
    beat("rst_b1", 32'h0000_2004, 32'h0000_0012, 4'b0001);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(mem_valid), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("midrst_nodone", 64'(st_done), 64'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("postrst_nodone", 64'(st_done), 64'd0);
    send(3'b010, 32'h0000_8000, 32'hCAFE_F00D);
    beat("postrst_b0", 32'h0000_8000, 32'hCAFE_F00D, 4'b1111);
    @(negedge clk);
    done("postrst", 1'b0);

    // split-disabled build: misaligned rejected, aligned passes
    r1_valid = 1'b1; r1_func3 = 3'b010; r1_addr = 32'h0000_4002; r1_data = 32'h1122_3344;
    chk("ns_ready", 64'(r1_ready), 64'd1);
    @(posedge clk);
    #1 r1_valid = 1'b0;
    @(negedge clk);
    chk("ns_mis_done",  64'(d1_done),  64'd1);
    chk("ns_mis_err",   64'(d1_err),   64'd1);
    chk("ns_mis_valid", 64'(m1_valid), 64'd0);
    r1_valid = 1'b1; r1_addr = 32'h0000_4000;
    @(posedge clk);
    #1 r1_valid = 1'b0;
    @(negedge clk);
    chk("ns_al_valid", 64'(m1_valid), 64'd1);
    chk("ns_al_addr",  64'(m1_addr),  64'h0000_4000);
    chk("ns_al_wdata", 64'(m1_wdata), 64'h1122_3344);
    chk("ns_al_wstrb", 64'(m1_wstrb), 64'hF);
    @(negedge clk);
    chk("ns_al_done", 64'(d1_done), 64'd1);
    chk("ns_al_err",  64'(d1_err),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
